// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer controller: register map, CTRL bits, FSM states.
// The DONE state only exists when PWM_TIMER_ONESHOT_EN is defined.
package pwm_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_PERIOD    = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE  = 3'd2;
    localparam logic [2:0] ADDR_FUNCTIONS = 3'd3;
    localparam logic [2:0] ADDR_COMPARE1  = 3'd4;
    localparam logic [2:0] ADDR_COMPARE2  = 3'd5;
    localparam logic [2:0] ADDR_STATUS    = 3'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int STATUS_WRAP  = 0;

    // functions[1:0] alignment encodings consumed by the PWM generator
    localparam logic [1:0] FUNC_LEFT      = 2'b00;
    localparam logic [1:0] FUNC_RIGHT     = 2'b01;
    localparam logic [1:0] FUNC_UNALIGNED = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef PWM_TIMER_ONESHOT_EN
        ST_DONE = 2'd2,
`endif
        ST_RUN  = 2'd1
    } pwm_state_e;

endpackage

// File: rtl/pwm_timer_ctrl_if.sv
// Register bus between a host and the PWM timer controller.
interface pwm_timer_ctrl_if;
    logic        wr_en;
    logic [2:0]  addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;

    modport master (output wr_en, addr, wr_data, rd_en, input rd_data);
    modport slave  (input wr_en, addr, wr_data, rd_en, output rd_data);
endinterface

// File: rtl/pwm_prescaler.sv
// Prescaler: counts 0..prescale while enabled and flags a tick on the terminal value.
module pwm_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PSC_W-1:0] prescale,
    input  logic             en,
    input  logic             clr,
    output logic             tick
);
    logic [PSC_W-1:0] cnt;

    assign tick = en && !clr && (cnt == prescale);

    // cnt above a freshly lowered prescale restarts without producing a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || clr || cnt >= prescale)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM timer controller: register file, staging/active shadow registers, period counter, FSM.
// Defining PWM_TIMER_ONESHOT_EN adds CTRL.ONESHOT and the DONE state.
module pwm_timer_ctrl
    import pwm_pkg::*;
#(
    parameter int PSC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_timer_ctrl_if.slave bus,
    output logic            pwm_en,
    output logic [15:0]     period,
    output logic [7:0]      functions,
    output logic [15:0]     compare1,
    output logic [15:0]     compare2,
    output logic [15:0]     count_val,
    output logic            wrap_irq
);
    // state | meaning
    // IDLE  | stopped; active regs follow staging every cycle
    // RUN   | counting; active regs reload from staging on wrap
    // DONE  | one-shot finished; counter held at 0 until EN is rewritten
    pwm_state_e state, state_nxt;

    logic             ctrl_en, ctrl_oneshot, wrap_sticky;
    logic [PSC_W-1:0] prescale;
    logic [15:0]      period_stg, period_nxt, cmp1_stg, cmp1_nxt, cmp2_stg, cmp2_nxt;
    logic [7:0]       func_stg, func_nxt;
    logic [15:0]      rd_q, rd_mux;
    logic             wr_ctrl, en_set, en_clr, clr_req, psc_clr, tick, wrap, copy_act;

    assign wr_ctrl  = bus.wr_en && (bus.addr == ADDR_CTRL);
    assign en_set   = wr_ctrl && bus.wr_data[CTRL_EN];
    assign en_clr   = wr_ctrl && !bus.wr_data[CTRL_EN];
    assign clr_req  = wr_ctrl && bus.wr_data[CTRL_CLR];
    assign psc_clr  = en_clr || clr_req;
    assign wrap     = tick && (count_val >= period);
    assign copy_act = (state == ST_IDLE) || wrap;
    assign bus.rd_data = rd_q;

    pwm_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .prescale (prescale),
        .en       (state == ST_RUN),
        .clr      (psc_clr),
        .tick     (tick)
    );

    // staging values including this cycle's write, so a write coincident with a wrap lands in active
    always_comb begin
        period_nxt = period_stg;
        func_nxt   = func_stg;
        cmp1_nxt   = cmp1_stg;
        cmp2_nxt   = cmp2_stg;
        if (bus.wr_en) begin
            case (bus.addr)
                ADDR_PERIOD:    period_nxt = bus.wr_data;
                ADDR_FUNCTIONS: func_nxt   = bus.wr_data[7:0];
                ADDR_COMPARE1:  cmp1_nxt   = bus.wr_data;
                ADDR_COMPARE2:  cmp2_nxt   = bus.wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en_set) state_nxt = ST_RUN;
            ST_RUN: begin
                if (en_clr)
                    state_nxt = ST_IDLE;
`ifdef PWM_TIMER_ONESHOT_EN
                else if (wrap && ctrl_oneshot)
                    state_nxt = ST_DONE;
`endif
            end
`ifdef PWM_TIMER_ONESHOT_EN
            ST_DONE: if (en_clr) state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]      = ctrl_en;
                rd_mux[CTRL_ONESHOT] = ctrl_oneshot;
            end
            ADDR_PERIOD:    rd_mux = period_stg;
            ADDR_PRESCALE:  rd_mux = 16'(prescale);
            ADDR_FUNCTIONS: rd_mux = {8'd0, func_stg};
            ADDR_COMPARE1:  rd_mux = cmp1_stg;
            ADDR_COMPARE2:  rd_mux = cmp2_stg;
            ADDR_STATUS:    rd_mux[STATUS_WRAP] = wrap_sticky;
            default:        rd_mux = '0;
        endcase
    end

`ifdef PWM_TIMER_ONESHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctrl_oneshot <= 1'b0;
        else if (wr_ctrl)
            ctrl_oneshot <= bus.wr_data[CTRL_ONESHOT];
    end
`else
    assign ctrl_oneshot = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pwm_en      <= 1'b0;
            wrap_irq    <= 1'b0;
            ctrl_en     <= 1'b0;
            wrap_sticky <= 1'b0;
            prescale    <= '0;
            period_stg  <= '0;
            func_stg    <= '0;
            cmp1_stg    <= '0;
            cmp2_stg    <= '0;
            period      <= '0;
            functions   <= '0;
            compare1    <= '0;
            compare2    <= '0;
            count_val   <= '0;
            rd_q        <= '0;
        end else begin
            state      <= state_nxt;
            pwm_en     <= (state_nxt == ST_RUN);
            wrap_irq   <= wrap;
            period_stg <= period_nxt;
            func_stg   <= func_nxt;
            cmp1_stg   <= cmp1_nxt;
            cmp2_stg   <= cmp2_nxt;
            if (wr_ctrl)
                ctrl_en <= bus.wr_data[CTRL_EN];
            if (bus.wr_en && bus.addr == ADDR_PRESCALE)
                prescale <= bus.wr_data[PSC_W-1:0];
            if (copy_act) begin
                period    <= period_nxt;
                functions <= func_nxt;
                compare1  <= cmp1_nxt;
                compare2  <= cmp2_nxt;
            end
            if (state != ST_RUN || psc_clr || wrap)
                count_val <= '0;
            else if (tick)
                count_val <= count_val + 16'd1;
            // a wrap in the same cycle as a clear request wins
            if (wrap)
                wrap_sticky <= 1'b1;
            else if (bus.wr_en && bus.addr == ADDR_STATUS && bus.wr_data[STATUS_WRAP])
                wrap_sticky <= 1'b0;
            if (bus.rd_en)
                rd_q <= rd_mux;
        end
    end
endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Bench for pwm_timer_ctrl: directed literal scenarios plus randomized traffic against a cycle model.
module tb_pwm_timer_ctrl;
    localparam int PSC_W = 8;
    localparam logic [15:0] PSC_MASK = 16'((1 << PSC_W) - 1);
    localparam logic [2:0] A_CTRL = 3'd0, A_PERIOD = 3'd1, A_PSC = 3'd2, A_FUNC = 3'd3,
                           A_CMP1 = 3'd4, A_CMP2 = 3'd5, A_STATUS = 3'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_en, wrap_irq;
    logic [15:0] period, compare1, compare2, count_val;
    logic [7:0] functions;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    pwm_timer_ctrl_if bus_if ();

    pwm_timer_ctrl #(.PSC_W(PSC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .pwm_en    (pwm_en),
        .period    (period),
        .functions (functions),
        .compare1  (compare1),
        .compare2  (compare2),
        .count_val (count_val),
        .wrap_irq  (wrap_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode;                 // 0 stopped, 1 counting, 2 one-shot finished
    logic [15:0] m_stg [0:7];   // host-visible register image by address
    logic [15:0] m_act_p, m_act_c1, m_act_c2;
    logic [7:0]  m_act_f;
    bit m_en, m_one, m_sticky, m_wirq, m_pwm;
    int m_psc, m_cnt;
    logic [15:0] m_rd;

    task automatic model_reset();
        m_mode = 0;
        foreach (m_stg[i]) m_stg[i] = '0;
        m_act_p = '0; m_act_c1 = '0; m_act_c2 = '0; m_act_f = '0;
        m_en = 0; m_one = 0; m_sticky = 0; m_wirq = 0; m_pwm = 0;
        m_psc = 0; m_cnt = 0; m_rd = '0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {13'd0, m_one, 1'b0, m_en};
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return m_stg[a];
            3'd6: return {15'd0, m_sticky};
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_step(input bit we, input logic [2:0] a, input logic [15:0] wd, input bit re);
        bit stop, clr, tick, wrap, was_idle, one_now;
        int lim;
        if (re) m_rd = model_read(a);
        stop     = we && a == A_CTRL && !wd[0];
        clr      = we && a == A_CTRL && wd[1];
        lim      = int'(m_stg[2]);
        one_now  = m_one;
        was_idle = (m_mode == 0);
        tick     = (m_mode == 1) && !stop && !clr && (m_psc == lim);
        wrap     = tick && (m_cnt >= int'(m_act_p));
        if (m_mode != 1 || stop || clr || m_psc >= lim) m_psc = 0; else m_psc++;
        if (m_mode != 1 || stop || clr || wrap) m_cnt = 0; else if (tick) m_cnt++;
        if (we) begin
            case (a)
                3'd0: begin
                    m_en = wd[0];
`ifdef PWM_TIMER_ONESHOT_EN
                    m_one = wd[2];
`endif
                end
                3'd1, 3'd4, 3'd5: m_stg[a] = wd;
                3'd2: m_stg[2] = wd & PSC_MASK;
                3'd3: m_stg[3] = wd & 16'h00FF;
                3'd6: if (wd[0]) m_sticky = 0;
                default: ;
            endcase
        end
        if (wrap) m_sticky = 1;
        if (was_idle || wrap) begin
            m_act_p = m_stg[1]; m_act_f = m_stg[3][7:0];
            m_act_c1 = m_stg[4]; m_act_c2 = m_stg[5];
        end
        case (m_mode)
            0: if (we && a == A_CTRL && wd[0]) m_mode = 1;
            1: if (stop) m_mode = 0; else if (wrap && one_now) m_mode = 2;
            default: if (stop) m_mode = 0;
        endcase
        m_wirq = wrap;
        m_pwm  = (m_mode == 1);
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (!rst_n) model_reset();
                chk("m_count_val", count_val, 16'(m_cnt));
                chk("m_pwm_en", 16'(pwm_en), 16'(m_pwm));
                chk("m_wrap_irq", 16'(wrap_irq), 16'(m_wirq));
                chk("m_period", period, m_act_p);
                chk("m_functions", 16'(functions), 16'(m_act_f));
                chk("m_compare1", compare1, m_act_c1);
                chk("m_compare2", compare2, m_act_c2);
                chk("m_rd_data", bus_if.rd_data, m_rd);
                if (rst_n) model_step(bus_if.wr_en, bus_if.addr, bus_if.wr_data, bus_if.rd_en);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus_if.wr_en = 1'b1; bus_if.addr = a; bus_if.wr_data = d;
        idle(1);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        bus_if.rd_en = 1'b1; bus_if.addr = a;
        idle(1);
        bus_if.rd_en = 1'b0;
    endtask

    initial begin
        logic [15:0] wd;
        logic [2:0]  a;
        int nw;
        bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0; bus_if.addr = '0; bus_if.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count_val", count_val, 16'd0);
        chk("rst_pwm_en", 16'(pwm_en), 16'd0);
        chk("rst_wrap_irq", 16'(wrap_irq), 16'd0);
        chk("rst_period", period, 16'd0);
        chk("rst_functions", 16'(functions), 16'd0);
        chk("rst_rd_data", bus_if.rd_data, 16'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // PERIOD=3, PRESCALE=0
        wr(A_PERIOD, 16'd3);
        wr(A_PSC, 16'd0);
        chk("r032_pwm_before", 16'(pwm_en), 16'd0);
        wr(A_CTRL, 16'h0001);
        chk("r032_pwm_en", 16'(pwm_en), 16'd1);
        for (int i = 0; i < 8; i++) begin
            chk("r032_count", count_val, 16'(i % 4));
            chk("r032_wrap", 16'(wrap_irq), 16'((i > 0 && i % 4 == 0) ? 1 : 0));
            idle(1);
        end

        // PRESCALE=2, PERIOD=1
        wr(A_CTRL, 16'h0000);
        wr(A_PSC, 16'd2);
        wr(A_PERIOD, 16'd1);
        wr(A_CTRL, 16'h0001);
        for (int i = 0; i < 13; i++) begin
            chk("r033_count", count_val, 16'((i / 3) % 2));
            chk("r033_wrap", 16'(wrap_irq), 16'((i > 0 && i % 6 == 0) ? 1 : 0));
            idle(1);
        end

        // shadowed COMPARE1 update
        wr(A_CTRL, 16'h0000);
        wr(A_PSC, 16'd0);
        wr(A_PERIOD, 16'd7);
        wr(A_FUNC, 16'h0002);
        wr(A_CMP1, 16'd2);
        chk("r034_cmp1_idle", compare1, 16'd2);
        chk("r034_func_idle", 16'(functions), 16'h0002);
        wr(A_CTRL, 16'h0001);
        idle(2);
        wr(A_CMP1, 16'd5);
        chk("r034_cmp1_held", compare1, 16'd2);
        rd(A_CMP1);
        chk("r034_readback", bus_if.rd_data, 16'd5);
        chk("r034_cmp1_still", compare1, 16'd2);
        for (int i = 0; i < 30 && !wrap_irq; i++) idle(1);
        chk("r034_wrap_seen", 16'(wrap_irq), 16'd1);
        chk("r034_cmp1_new", compare1, 16'd5);

`ifdef PWM_TIMER_ONESHOT_EN
        wr(A_CTRL, 16'h0000);
        wr(A_PERIOD, 16'd2);
        wr(A_CTRL, 16'h0005);
        nw = 0;
        for (int i = 0; i < 12; i++) begin
            if (wrap_irq) nw++;
            idle(1);
        end
        chk("r035_one_wrap", 16'(nw), 16'd1);
        chk("r035_pwm_off", 16'(pwm_en), 16'd0);
        chk("r035_count_held", count_val, 16'd0);
        wr(A_CTRL, 16'h0004);
        wr(A_CTRL, 16'h0005);
        chk("r035_restart_pwm", 16'(pwm_en), 16'd1);
        idle(1);
        chk("r035_restart_count", count_val, 16'd1);
`else
        wr(A_CTRL, 16'h0005);
        rd(A_CTRL);
        chk("r029_oneshot_ignored", bus_if.rd_data, 16'h0001);
`endif

        // STATUS clear racing a wrap, then CLR
        wr(A_CTRL, 16'h0000);
        wr(A_PERIOD, 16'd3);
        wr(A_CTRL, 16'h0001);
        for (int i = 0; i < 20 && count_val != 16'd3; i++) idle(1);
        chk("r036_reach3", count_val, 16'd3);
        wr(A_STATUS, 16'h0001);
        chk("r036_wrap_irq", 16'(wrap_irq), 16'd1);
        rd(A_STATUS);
        chk("r036_sticky_kept", bus_if.rd_data, 16'h0001);
        wr(A_STATUS, 16'h0001);
        rd(A_STATUS);
        chk("r036_sticky_cleared", bus_if.rd_data, 16'h0000);
        chk("r021_pre_clr_count", count_val, 16'd3);
        wr(A_CTRL, 16'h0003);
        chk("r021_clr_count", count_val, 16'd0);
        chk("r021_clr_no_wrap", 16'(wrap_irq), 16'd0);
        rd(A_CTRL);
        chk("r021_clr_reads0", bus_if.rd_data, 16'h0001);
        chk("r021_count_resume", count_val, 16'd1);

        // asynchronous reset mid-count
        idle(2);
        #1 rst_n = 1'b0;
        #1;
        chk("r027_count", count_val, 16'd0);
        chk("r027_pwm_en", 16'(pwm_en), 16'd0);
        chk("r027_wrap_irq", 16'(wrap_irq), 16'd0);
        chk("r027_period", period, 16'd0);
        chk("r027_compare1", compare1, 16'd0);
        chk("r027_functions", 16'(functions), 16'd0);
        chk("r027_rd_data", bus_if.rd_data, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // randomized register traffic
        for (int c = 0; c < 1500; c++) begin
            a  = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            case (a)
                A_CTRL: begin
                    wd[0] = ($urandom_range(0, 7) != 0);
                    wd[1] = ($urandom_range(0, 7) == 0);
                    wd[2] = ($urandom_range(0, 3) == 0);
                end
                A_PERIOD: wd = 16'($urandom_range(0, 5));
                A_PSC:    wd[7:0] = 8'($urandom_range(0, 3));
                default: ;
            endcase
            bus_if.addr    = a;
            bus_if.wr_data = wd;
            bus_if.wr_en   = ($urandom_range(0, 2) == 0);
            bus_if.rd_en   = ($urandom_range(0, 1) == 0);
            idle(1);
        end
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        idle(3);
        chk_on = 1'b0;
        idle(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_timer_ctrl.md
PWM_TIMER_CTRL -- requirements
Module: pwm_timer_ctrl

Interface
REQ-001 Parameter PSC_W, default 8, prescaler register width.
REQ-002 Port clk  input  1  peripheral clock; all logic on rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-005 Port addr  input  3  register address, shared by read and write.
REQ-006 Port wr_data  input  16  write data; narrower registers take LSBs.
REQ-007 Port rd_en  input  1  register read strobe.
REQ-008 Port rd_data  output  16  read data, valid one cycle after rd_en.
REQ-009 Ports pwm_en (1), period (16), functions (8), compare1 (16), compare2 (16), count_val (16)  output  drive the PWM generator.
REQ-010 Port wrap_irq  output  1  one-cycle pulse on each counter wrap.

Function
REQ-011 Register map: 0 CTRL (bit0 EN, bit1 CLR self-clearing, bit2 ONESHOT), 1 PERIOD, 2 PRESCALE, 3 FUNCTIONS, 4 COMPARE1, 5 COMPARE2, 6 STATUS (bit0 WRAP sticky, write-1-to-clear), 7 reads 0.
REQ-012 PERIOD, FUNCTIONS, COMPARE1 and COMPARE2 writes go to staging registers; outputs period/functions/compare1/compare2 come from active (shadow) registers.
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN when EN written 1; RUN/DONE->IDLE when EN written 0; RUN->DONE on wrap when ONESHOT=1.
REQ-014 In IDLE: count_val=0, prescaler=0, pwm_en=0, and the staging->active copy happens every cycle (writes take effect the next cycle).
REQ-015 In RUN: prescaler counts 0..PRESCALE; the cycle it equals PRESCALE is a tick, and it then restarts at 0; PRESCALE=0 gives a tick every cycle.
REQ-016 On tick with count_val < active period: count_val increments by 1.
REQ-017 On tick with count_val == active period: count_val <= 0, staging copied to active, wrap_irq pulses the next cycle, STATUS.WRAP set.
REQ-018 Active period 0: count_val stays 0 and every tick is a wrap.
REQ-019 pwm_en = 1 only in RUN, registered, asserted the cycle after the EN write.
REQ-020 In DONE: count_val held at 0, pwm_en=0, no further wraps; re-entering RUN requires an EN 0->1 write.
REQ-021 CLR write: count_val and prescaler go to 0 the next cycle without a wrap, active registers unchanged; the CTRL readback of CLR is always 0.
REQ-022 A staging write in the same cycle as a wrap: the new write data is copied to active.
REQ-023 A STATUS clear in the same cycle as a wrap: WRAP stays 1.
REQ-024 A PRESCALE write takes effect immediately; if the prescaler is above the new value, it restarts at 0 without a tick.
REQ-025 rd_data reads staging registers (not active), registered, and holds its value when rd_en=0.

Reset
REQ-026 rst_n low: FSM=IDLE; all registers, staging, active, count_val, prescaler, rd_data, wrap_irq, pwm_en = 0; functions=0.
REQ-027 Reset mid-RUN aborts immediately and asynchronously; no wrap_irq is emitted.

Configuration
REQ-028 Macro PWM_TIMER_ONESHOT_EN defined: CTRL.ONESHOT and the DONE state are implemented.
REQ-029 Macro PWM_TIMER_ONESHOT_EN undefined: ONESHOT reads 0, writes to it are ignored, the FSM is IDLE/RUN only, and the counter free-runs.

Structure
REQ-030 Shared package pwm_pkg: register address constants, FSM state enum, CTRL bit indices, functions encodings (00 left, 01 right, 10 unaligned).
REQ-031 One sub-module, pwm_prescaler (PSC_W-bit counter producing tick; inputs PRESCALE, enable and clear).

Verification
REQ-032 PERIOD=3, PRESCALE=0, EN=1 -> count_val 0,1,2,3,0...; wrap_irq every 4 cycles; pwm_en high from the cycle after the write.
REQ-033 PRESCALE=2, PERIOD=1 -> count_val advances every 3 cycles; wrap every 6 cycles.
REQ-034 Running with COMPARE1=2; write COMPARE1=5 mid-period -> compare1 output stays 2 until the wrap, then becomes 5; readback returns 5 immediately.
REQ-035 ONESHOT=1, PERIOD=2 -> one wrap_irq, then pwm_en=0 and count_val=0 held; EN write 0 then 1 restarts the counter.
REQ-036 STATUS W1C written in the wrap cycle -> WRAP reads 1; rst_n pulsed mid-count -> all outputs 0 immediately.
